// File: rtl/if_id_queue_pkg.sv
// Shared CPU constants and the queue entry type for the fetch/decode boundary.
package if_id_queue_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 16;

    localparam logic [3:0] HLT_OPC = 4'b1111;
    localparam logic [3:0] JAL_OPC = 4'b1101;

    localparam logic [INSTR_W-1:0] BUBBLE_INSTR_DEF = 16'h0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

endpackage

// File: rtl/if_id_fifo_mem.sv
// DEPTH x {instr, pc} register array: one synchronous write port, asynchronous head read.
module if_id_fifo_mem
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  entry_t        wdata,
    input  logic [AW-1:0] raddr,
    output entry_t        rdata
);

    entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling FIFO between fetch and decode, with flush and halt intake freeze.
// Optional perf counters (stall_cnt, flush_cnt) under IF_ID_QUEUE_PERF_EN.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int                 DEPTH        = 2,
    parameter logic [INSTR_W-1:0] BUBBLE_INSTR = BUBBLE_INSTR_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [ADDR_W-1:0]  in_pc,
    input  logic               in_valid,
    output logic               if_ready,
    input  logic               flush,
    input  logic               stall,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc1,
    output logic               id_valid,
`ifdef IF_ID_QUEUE_PERF_EN
    output logic [15:0]        stall_cnt,
    output logic [15:0]        flush_cnt,
`endif
    output logic               hlt_seen
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          hlt_q;
    logic          enq, deq;
    entry_t        head;

    // Handshake: a word transfers on an edge where in_valid && if_ready (upstream side)
    // or id_valid && !stall (downstream side); flush cancels both transfers that cycle.
    assign if_ready = (count < CW'(DEPTH)) && !hlt_q;
    assign id_valid = (count != '0);
    assign enq      = in_valid && if_ready && !flush;
    assign deq      = id_valid && !stall && !flush;
    assign hlt_seen = hlt_q;

    if_id_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (enq && rst_n),
        .waddr (wr_ptr),
        .wdata ('{instr: in_instr, pc: in_pc}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hlt_q  <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (in_instr[15:12] == HLT_OPC) begin
                    hlt_q <= 1'b1;
                end
            end
            if (deq) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (enq && !deq) begin
                count <= count + CW'(1);
            end else if (!enq && deq) begin
                count <= count - CW'(1);
            end
        end
    end

    // Empty queue reads as pc 0 so id_pc1 is a defined 16'h0001 rather than stale storage.
    assign id_instr = id_valid ? head.instr : BUBBLE_INSTR;
    assign id_pc1   = (id_valid ? head.pc : '0) + ADDR_W'(1);

`ifdef IF_ID_QUEUE_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (id_valid && stall && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (flush && flush_cnt != 16'hFFFF) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
